// File: rtl/ccff_loader_pkg.sv
// Shared definitions for the configuration-chain loader: FSM states,
// CRC-16/CCITT constants and the byte-wide CRC update.
package ccff_loader_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FETCH  = 3'd1,
      SHIFT  = 3'd2,
      CRC_HI = 3'd3,
      CRC_LO = 3'd4,
      CHECK  = 3'd5
   } state_t;

   localparam logic [15:0] CRC_POLY = 16'h1021;
   localparam logic [15:0] CRC_SEED = 16'hFFFF;

   // MSB-first, unreflected CRC-16 update over one full byte
   function automatic logic [15:0] crc16_byte_next(input logic [15:0] crc_in,
                                                   input logic [7:0]  data);
      logic [15:0] c;
      c = crc_in;
      for (int i = 7; i >= 0; i--) begin
         if (c[15] ^ data[i])
            c = {c[14:0], 1'b0} ^ CRC_POLY;
         else
            c = {c[14:0], 1'b0};
      end
      return c;
   endfunction

endpackage

// File: rtl/ccff_clkgen.sv
// Divides clk into prog_clk while enabled; rise_en/fall_en flag the clk
// cycle at whose end prog_clk will rise/fall. Disabled means parked low.
module ccff_clkgen #(
   parameter int CLK_DIV = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic enable,
   output logic prog_clk,
   output logic rise_en,
   output logic fall_en
);

   localparam int            CW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);

   logic [CW-1:0] div_cnt;
   logic          wrap;

   assign wrap    = enable && (div_cnt == DIV_LAST);
   assign rise_en = wrap && !prog_clk;
   assign fall_en = wrap && prog_clk;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt  <= '0;
         prog_clk <= 1'b0;
      end else if (!enable) begin
         div_cnt  <= '0;
         prog_clk <= 1'b0;
      end else if (wrap) begin
         div_cnt  <= '0;
         prog_clk <= !prog_clk;
      end else begin
         div_cnt  <= div_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/ccff_loader.sv
// Streams a CRC-protected bitstream into a fabric configuration chain,
// one bit per prog_clk period, and reports the CRC verdict.
module ccff_loader
   import ccff_loader_pkg::*;
#(
   parameter int CHAIN_LEN = 128,
   parameter int CLK_DIV   = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [7:0] s_data,
   input  logic       s_valid,
   output logic       s_ready,
   output logic       prog_clk,
   output logic       ccff_head,
   output logic       busy,
   output logic       done,
   output logic       crc_err
);

   localparam int            BW       = $clog2(CHAIN_LEN + 1);
   localparam logic [BW-1:0] LAST_BIT = BW'(CHAIN_LEN);

   state_t        state, next_state;
   logic [6:0]    shift_reg;
   logic [3:0]    byte_bits;
   logic [BW-1:0] bit_cnt;
   logic [15:0]   crc, rx_crc;
   logic          handshake, rise_en, fall_en;
   logic          chain_full, byte_empty, crc_match;

   assign s_ready    = (state == FETCH) || (state == CRC_HI) || (state == CRC_LO);
   assign handshake  = s_valid && s_ready;
   assign chain_full = (bit_cnt == LAST_BIT);
   assign byte_empty = (byte_bits == 4'd8);
   assign crc_match  = (crc == rx_crc);
   assign busy       = (state != IDLE);
   assign done       = (state == CHECK) && crc_match;

   ccff_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
      .clk      (clk),
      .rst_n    (rst_n),
      .enable   (state == SHIFT),
      .prog_clk (prog_clk),
      .rise_en  (rise_en),
      .fall_en  (fall_en)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= next_state;
   end

   // SHIFT is only left on a falling edge so prog_clk always parks low
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (start) next_state = FETCH;
         FETCH:   if (handshake) next_state = SHIFT;
         SHIFT: begin
            if (fall_en) begin
               if (chain_full)
                  next_state = CRC_HI;
               else if (byte_empty)
                  next_state = FETCH;
            end
         end
         CRC_HI:  if (handshake) next_state = CRC_LO;
         CRC_LO:  if (handshake) next_state = CHECK;
         CHECK:   next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // ccff_head carries the current bit; shift_reg holds the rest of the byte
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shift_reg <= '0;
         byte_bits <= '0;
         bit_cnt   <= '0;
         crc       <= CRC_SEED;
         rx_crc    <= '0;
         ccff_head <= 1'b0;
         crc_err   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  crc_err <= 1'b0;
                  bit_cnt <= '0;
                  crc     <= CRC_SEED;
               end
            end
            FETCH: begin
               if (handshake) begin
                  ccff_head <= s_data[7];
                  shift_reg <= s_data[6:0];
                  byte_bits <= '0;
                  crc       <= crc16_byte_next(crc, s_data);
               end
            end
            SHIFT: begin
               if (rise_en) begin
                  bit_cnt   <= bit_cnt + 1'b1;
                  byte_bits <= byte_bits + 1'b1;
               end
               if (fall_en && !chain_full && !byte_empty) begin
                  ccff_head <= shift_reg[6];
                  shift_reg <= {shift_reg[5:0], 1'b0};
               end
            end
            CRC_HI:  if (handshake) rx_crc[15:8] <= s_data;
            CRC_LO:  if (handshake) rx_crc[7:0]  <= s_data;
            CHECK:   if (!crc_match) crc_err <= 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ccff_loader.sv
// Scoreboard bench for ccff_loader: a 16-bit and a 12-bit chain instance,
// expected chain bits and load verdicts queued by the stimulus side.
module tb_ccff_loader;

   localparam int LIMIT = 2000;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [1:0] start, s_valid, s_ready, prog_clk, ccff_head, busy, done, crc_err;
   logic [7:0] s_data [2];

   int         total = 0;
   int         bad   = 0;
   bit         exp_bits [$];
   logic [1:0] exp_res  [$];
   int         rise_cnt [2];
   logic [1:0] prev_pc, prev_busy, done_seen;

   always #5 clk = ~clk;

   ccff_loader #(.CHAIN_LEN(16), .CLK_DIV(2)) dut16 (
      .clk(clk), .rst_n(rst_n), .start(start[0]), .s_data(s_data[0]),
      .s_valid(s_valid[0]), .s_ready(s_ready[0]), .prog_clk(prog_clk[0]),
      .ccff_head(ccff_head[0]), .busy(busy[0]), .done(done[0]), .crc_err(crc_err[0])
   );

   ccff_loader #(.CHAIN_LEN(12), .CLK_DIV(2)) dut12 (
      .clk(clk), .rst_n(rst_n), .start(start[1]), .s_data(s_data[1]),
      .s_valid(s_valid[1]), .s_ready(s_ready[1]), .prog_clk(prog_clk[1]),
      .ccff_head(ccff_head[1]), .busy(busy[1]), .done(done[1]), .crc_err(crc_err[1])
   );

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic fail_now(input string name);
      total++;
      bad++;
      $display("[TB] FAIL %s: event did not occur as required", name);
   endtask

   // Reference CRC-16/CCITT (seed FFFF, no reflection) over a two-byte payload
   function automatic logic [15:0] crc_model(input logic [7:0] b0, input logic [7:0] b1);
      logic [15:0] m;
      logic [15:0] c;
      bit          fb;
      m = {b0, b1};
      c = 16'hFFFF;
      for (int i = 15; i >= 0; i--) begin
         fb = c[15] ^ m[i];
         c  = c << 1;
         if (fb) c = c ^ 16'h1021;
      end
      return c;
   endfunction

   // Monitor: each prog_clk rise is checked against the next expected chain bit,
   // each end of a load against the expected {done seen, crc_err}
   initial begin
      bit         b;
      logic [1:0] r;
      prev_pc   = '0;
      prev_busy = '0;
      done_seen = '0;
      rise_cnt  = '{0, 0};
      forever begin
         @(negedge clk);
         for (int d = 0; d < 2; d++) begin
            if (prog_clk[d] && !prev_pc[d]) begin
               rise_cnt[d]++;
               if (exp_bits.size() == 0)
                  fail_now($sformatf("unexpected_rise_dut%0d", d));
               else begin
                  b = exp_bits.pop_front();
                  check_output($sformatf("ccff_head_dut%0d_rise%0d", d, rise_cnt[d]), ccff_head[d], b);
               end
            end
            if (done[d]) done_seen[d] = 1'b1;
            if (prev_busy[d] && !busy[d] && rst_n) begin
               if (exp_res.size() == 0)
                  fail_now($sformatf("unexpected_load_end_dut%0d", d));
               else begin
                  r = exp_res.pop_front();
                  check_output($sformatf("done_and_crc_err_dut%0d", d), {done_seen[d], crc_err[d]}, r);
               end
               done_seen[d] = 1'b0;
            end
            if (!rst_n) done_seen[d] = 1'b0;
            prev_pc[d]   = prog_clk[d];
            prev_busy[d] = busy[d];
         end
      end
   end

   task automatic pulse_start(input int d);
      @(negedge clk);
      start[d] = 1'b1;
      @(negedge clk);
      start[d] = 1'b0;
   endtask

   task automatic wait_ready(input int d, output bit ok);
      int n;
      n = 0;
      while (!s_ready[d] && n < LIMIT) begin
         @(negedge clk);
         n++;
      end
      ok = (n < LIMIT);
   endtask

   // Optional gap: once the loader asks for the byte, withhold it for gap cycles
   task automatic apply_stimulus(input int d, input logic [7:0] b, input int gap);
      bit ok;
      int high_cnt;
      @(negedge clk);
      if (gap > 0) begin
         wait_ready(d, ok);
         if (!ok) fail_now("ready_before_gap_timeout");
         high_cnt = 0;
         repeat (gap) begin
            @(negedge clk);
            if (prog_clk[d]) high_cnt++;
         end
         check_output("prog_clk_low_during_gap", high_cnt, 0);
      end
      s_data[d]  = b;
      s_valid[d] = 1'b1;
      wait_ready(d, ok);
      if (!ok)
         fail_now("handshake_timeout");
      else begin
         @(posedge clk);
         #1;
      end
      s_valid[d] = 1'b0;
   endtask

   // One complete load: two payload bytes, CRC (optionally corrupted), verdict
   task automatic run_load(input int d, input logic [7:0] b0, input logic [7:0] b1,
                           input logic [15:0] bits, input int nbits, input logic [15:0] crc_flip,
                           input logic [1:0] res, input int gap, input bit extra_start);
      logic [15:0] c;
      int          r0;
      int          n;
      c  = crc_model(b0, b1) ^ crc_flip;
      r0 = rise_cnt[d];
      for (int i = 15; i >= 16 - nbits; i--) exp_bits.push_back(bits[i]);
      exp_res.push_back(res);
      pulse_start(d);
      check_output("crc_err_cleared_by_start", crc_err[d], 1'b0);
      apply_stimulus(d, b0, 0);
      apply_stimulus(d, b1, gap);
      if (extra_start) begin
         pulse_start(d);
         check_output("busy_start_keeps_crc_err", crc_err[d], 1'b0);
      end
      apply_stimulus(d, c[15:8], 0);
      apply_stimulus(d, c[7:0], 0);
      n = 0;
      while (busy[d] && n < LIMIT) begin
         @(negedge clk);
         n++;
      end
      if (n >= LIMIT) fail_now("load_end_timeout");
      repeat (3) @(negedge clk);
      check_output("prog_clk_rise_count", rise_cnt[d] - r0, nbits);
      check_output("all_bits_clocked", exp_bits.size(), 0);
      check_output("verdict_reported", exp_res.size(), 0);
   endtask

   initial begin
      int r0;
      int n;
      rst_n      = 1'b1;
      start      = '0;
      s_valid    = '0;
      s_data[0]  = '0;
      s_data[1]  = '0;
      #1 rst_n = 1'b0;
      #1;
      check_output("reset_busy",      busy,      2'b00);
      check_output("reset_s_ready",   s_ready,   2'b00);
      check_output("reset_prog_clk",  prog_clk,  2'b00);
      check_output("reset_ccff_head", ccff_head, 2'b00);
      check_output("reset_done",      done,      2'b00);
      check_output("reset_crc_err",   crc_err,   2'b00);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      $display("[TB] 16-bit chain, A5 3C");
      run_load(0, 8'hA5, 8'h3C, 16'b1010010100111100, 16, 16'h0000, 2'b10, 0, 1'b0);

      $display("[TB] 12-bit chain, FF F0, trailing bits discarded");
      run_load(1, 8'hFF, 8'hF0, 16'b1111111111110000, 12, 16'h0000, 2'b10, 0, 1'b0);

      $display("[TB] corrupted CRC low byte");
      run_load(0, 8'hA5, 8'h3C, 16'b1010010100111100, 16, 16'h0001, 2'b01, 0, 1'b0);
      repeat (10) @(negedge clk);
      check_output("crc_err_sticky", crc_err[0], 1'b1);
      check_output("done_low_after_error", done[0], 1'b0);

      $display("[TB] 20-cycle s_valid gap between bytes");
      run_load(0, 8'hA5, 8'h3C, 16'b1010010100111100, 16, 16'h0000, 2'b10, 20, 1'b0);

      $display("[TB] start pulse while busy");
      run_load(0, 8'h5A, 8'hC3, 16'b0101101011000011, 16, 16'h0000, 2'b10, 0, 1'b1);

      $display("[TB] reset during bit 5 of first byte");
      exp_bits.push_back(1'b1);
      exp_bits.push_back(1'b0);
      exp_bits.push_back(1'b1);
      exp_bits.push_back(1'b0);
      exp_bits.push_back(1'b0);
      r0 = rise_cnt[0];
      pulse_start(0);
      apply_stimulus(0, 8'hA5, 0);
      n = 0;
      while ((rise_cnt[0] - r0) < 5 && n < LIMIT) begin
         @(negedge clk);
         n++;
      end
      if (n >= LIMIT) fail_now("five_rises_timeout");
      repeat (3) @(negedge clk);
      check_output("head_before_reset", ccff_head[0], 1'b1);
      #1 rst_n = 1'b0;
      #1;
      check_output("midload_reset_busy",      busy[0],      1'b0);
      check_output("midload_reset_s_ready",   s_ready[0],   1'b0);
      check_output("midload_reset_prog_clk",  prog_clk[0],  1'b0);
      check_output("midload_reset_ccff_head", ccff_head[0], 1'b0);
      check_output("midload_reset_done",      done[0],      1'b0);
      check_output("midload_reset_crc_err",   crc_err[0],   1'b0);
      r0 = rise_cnt[0];
      exp_bits.delete();
      repeat (10) @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      check_output("no_rise_after_reset", rise_cnt[0] - r0, 0);

      $display("[TB] full load after reset");
      run_load(0, 8'hA5, 8'h3C, 16'b1010010100111100, 16, 16'h0000, 2'b10, 0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation did not complete in time");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
